psum_rmw_ctrl: RTL and testbench

Read-modify-write sequencer for the PSUM SRAM, the producer side of the per-lane SFP datapath. For each output row it pops the OFIFO, reads the stored partial sum, combines the two per lane (passthrough, accumulate or ReLU) and writes the result back to the same address. It sits between the OFIFO, the single-port PSUM SRAM and the top-level controller, which issues one pass per kernel tile.

---
 rtl/psum_rmw_ctrl_pkg.sv | 25 ++
 rtl/psum_rmw_ctrl_if.sv | 30 +++
 rtl/psum_rmw_ctrl_lane.sv | 19 +
 rtl/psum_rmw_ctrl.sv | 110 +++++++++++
 tb/tb_psum_rmw_ctrl.sv | 259 +++++++++++++++++++++++++
 5 files changed

// File: rtl/psum_rmw_ctrl_pkg.sv
// Shared encodings and geometry for the PSUM read-modify-write sequencer.
// Mode 3 is folded onto ReLU when the pass parameters are latched.
package psum_rmw_ctrl_pkg;
   localparam int COL     = 8;
   localparam int PSUM_BW = 16;
   localparam int ADDR_BW = 11;
   localparam int ROW_BW  = COL * PSUM_BW;

   typedef enum logic [1:0] {
      MODE_PASS = 2'd0,
      MODE_ACC  = 2'd1,
      MODE_RELU = 2'd2
   } mode_e;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_RD   = 2'd1,
      S_WR   = 2'd2,
      S_DONE = 2'd3
   } state_e;

   function automatic mode_e norm_mode(input logic [1:0] m);
      return (m == 2'd3) ? MODE_RELU : mode_e'(m);
   endfunction
endpackage

// File: rtl/psum_rmw_ctrl_if.sv
// Bundle of controller, OFIFO and PSUM SRAM signals around the RMW sequencer.
// The slave modport is the sequencer; the master modport is its environment.
interface psum_rmw_ctrl_if;
   import psum_rmw_ctrl_pkg::*;

   logic               start;
   logic [1:0]         mode;
   logic [ADDR_BW-1:0] base_addr;
   logic [ADDR_BW-1:0] count;
   logic               ofifo_valid;
   logic [ROW_BW-1:0]  ofifo_out;
   logic               ofifo_rd;
   logic               sram_cen;
   logic               sram_wen;
   logic [ADDR_BW-1:0] sram_addr;
   logic [ROW_BW-1:0]  sram_d;
   logic [ROW_BW-1:0]  sram_q;
   logic               busy;
   logic               done;

   modport slave (
      input  start, mode, base_addr, count, ofifo_valid, ofifo_out, sram_q,
      output ofifo_rd, sram_cen, sram_wen, sram_addr, sram_d, busy, done
   );

   modport master (
      output start, mode, base_addr, count, ofifo_valid, ofifo_out, sram_q,
      input  ofifo_rd, sram_cen, sram_wen, sram_addr, sram_d, busy, done
   );
endinterface

// File: rtl/psum_rmw_ctrl_lane.sv
// One lane of the combine datapath: passthrough, wrapping accumulate, or ReLU
// of the stored partial sum, all in two's complement.
module psum_lane
   import psum_rmw_ctrl_pkg::*;
(
   input  mode_e              mode_i,
   input  logic [PSUM_BW-1:0] sram_q_i,
   input  logic [PSUM_BW-1:0] ofifo_i,
   output logic [PSUM_BW-1:0] d_o
);
   always_comb begin
      d_o = ofifo_i;
      case (mode_i)
         MODE_ACC:  d_o = sram_q_i + ofifo_i;
         MODE_RELU: d_o = sram_q_i[PSUM_BW-1] ? '0 : sram_q_i;
         default:   d_o = ofifo_i;
      endcase
   end
endmodule

// File: rtl/psum_rmw_ctrl.sv
// PSUM SRAM read-modify-write sequencer: per row, pop the OFIFO, read the
// stored partial sum, combine per lane and write back to the same address.
module psum_rmw_ctrl
   import psum_rmw_ctrl_pkg::*;
(
   input  logic           clk,
   input  logic           reset,
   psum_rmw_ctrl_if.slave bus
);
   state_e             state_q, state_d;
   mode_e              mode_q;
   logic [ADDR_BW-1:0] count_q, idx_q, addr_q;
   logic [ROW_BW-1:0]  ofifo_q;
   logic               wen_q, busy_q, done_q;
   logic               rd_go, wr_go, last_row;
   logic [ROW_BW-1:0]  lane_ofifo, lane_d;

   assign last_row = (idx_q == count_q - ADDR_BW'(1));

   always_comb begin
      state_d      = state_q;
      rd_go        = 1'b0;
      wr_go        = 1'b0;
      bus.sram_cen = 1'b1;
      bus.ofifo_rd = 1'b0;
      case (state_q)
         S_IDLE: begin
            if (bus.start) begin
               if (bus.count == '0)
                  state_d = S_DONE;
               else if (norm_mode(bus.mode) == MODE_PASS)
                  state_d = S_WR;
               else
                  state_d = S_RD;
            end
         end
         S_RD: begin
            // Only accumulate needs an OFIFO row; ReLU reads unconditionally.
            if (!(mode_q == MODE_ACC && !bus.ofifo_valid)) begin
               rd_go        = 1'b1;
               bus.sram_cen = 1'b0;
               bus.ofifo_rd = (mode_q == MODE_ACC);
               state_d      = S_WR;
            end
         end
         S_WR: begin
            if (!(mode_q == MODE_PASS && !bus.ofifo_valid)) begin
               wr_go        = 1'b1;
               bus.sram_cen = 1'b0;
               bus.ofifo_rd = (mode_q == MODE_PASS);
               if (last_row)
                  state_d = S_DONE;
               else
                  state_d = (mode_q == MODE_PASS) ? S_WR : S_RD;
            end
         end
         S_DONE:  state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q <= S_IDLE;
         mode_q  <= MODE_PASS;
         count_q <= '0;
         idx_q   <= '0;
         addr_q  <= '0;
         ofifo_q <= '0;
         wen_q   <= 1'b1;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         wen_q   <= (state_d != S_WR);
         busy_q  <= (state_d == S_RD) || (state_d == S_WR);
         done_q  <= (state_d == S_DONE);
         if (state_q == S_IDLE && bus.start) begin
            mode_q  <= norm_mode(bus.mode);
            count_q <= bus.count;
            idx_q   <= '0;
            addr_q  <= bus.base_addr;
         end
         if (wr_go) begin
            idx_q  <= idx_q + ADDR_BW'(1);
            addr_q <= addr_q + ADDR_BW'(1);
         end
         if (rd_go && mode_q == MODE_ACC)
            ofifo_q <= bus.ofifo_out;
      end
   end

   // Passthrough writes the live OFIFO head in the pop cycle; accumulate uses the row held since RD.
   assign lane_ofifo = (mode_q == MODE_PASS) ? bus.ofifo_out : ofifo_q;

   for (genvar gi = 0; gi < COL; gi++) begin : g_lane
      psum_lane u_lane (
         .mode_i   (mode_q),
         .sram_q_i (bus.sram_q[gi*PSUM_BW +: PSUM_BW]),
         .ofifo_i  (lane_ofifo[gi*PSUM_BW +: PSUM_BW]),
         .d_o      (lane_d[gi*PSUM_BW +: PSUM_BW])
      );
   end

   assign bus.sram_d    = (state_q == S_WR) ? lane_d : '0;
   assign bus.sram_wen  = wen_q;
   assign bus.sram_addr = addr_q;
   assign bus.busy      = busy_q;
   assign bus.done      = done_q;
endmodule

// File: tb/tb_psum_rmw_ctrl.sv
// Bench for psum_rmw_ctrl: SRAM and show-ahead OFIFO models plus a row-level
// reference of the expected write stream, done latency and pop count.
module tb_psum_rmw_ctrl;
   import psum_rmw_ctrl_pkg::*;

   logic clk = 1'b0;
   logic reset;
   always #5 clk = ~clk;

   psum_rmw_ctrl_if bus ();
   psum_rmw_ctrl dut (.clk(clk), .reset(reset), .bus(bus));

   int tests = 0;
   int fails = 0;

   logic [ROW_BW-1:0]  mem [0:(1<<ADDR_BW)-1];
   logic [ROW_BW-1:0]  fifo [$];
   bit                 hold = 1'b0;
   logic               pl_we = 1'b0;
   logic [ADDR_BW-1:0] pl_addr = '0;
   logic [ROW_BW-1:0]  pl_data = '0;

   int cyc = 0, start_cyc = 0, done_cyc = 0, done_cnt = 0, pop_cnt = 0, cen_lo_cnt = 0;
   logic [ADDR_BW-1:0] wl_addr [$];
   logic [ROW_BW-1:0]  wl_data [$];
   int                 wl_cyc  [$];

   // SRAM, OFIFO and event log; every value is sampled at the edge before DUT updates land.
   always @(posedge clk) begin
      cyc <= cyc + 1;
      if (pl_we) mem[pl_addr] <= pl_data;
      if (!bus.sram_cen) begin
         cen_lo_cnt <= cen_lo_cnt + 1;
         if (bus.sram_wen) bus.sram_q <= mem[bus.sram_addr];
         else begin
            mem[bus.sram_addr] <= bus.sram_d;
            wl_addr.push_back(bus.sram_addr);
            wl_data.push_back(bus.sram_d);
            wl_cyc.push_back(cyc);
         end
      end
      if (bus.ofifo_rd) begin
         pop_cnt <= pop_cnt + 1;
         if (fifo.size() > 0) void'(fifo.pop_front());
      end
      if (bus.start) start_cyc <= cyc;
      if (bus.done) begin
         done_cnt <= done_cnt + 1;
         done_cyc <= cyc;
      end
      bus.ofifo_valid <= (fifo.size() > 0) && !hold;
      bus.ofifo_out   <= (fifo.size() > 0) ? fifo[0] : '0;
   end

   task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   function automatic logic [ROW_BW-1:0] rand_row();
      logic [ROW_BW-1:0] r;
      r = '0;
      for (int k = 0; k < COL; k++) r[k*PSUM_BW +: PSUM_BW] = PSUM_BW'($urandom);
      return r;
   endfunction

   // Reference lane semantics on signed integers, truncated back to the lane width.
   function automatic logic [ROW_BW-1:0] ref_row(input int m, input logic [ROW_BW-1:0] s,
                                                 input logic [ROW_BW-1:0] o);
      logic [ROW_BW-1:0] r;
      r = '0;
      for (int k = 0; k < COL; k++) begin
         int sv, ov, res;
         sv = int'($signed(s[k*PSUM_BW +: PSUM_BW]));
         ov = int'($signed(o[k*PSUM_BW +: PSUM_BW]));
         if (m == 0)      res = ov;
         else if (m == 1) res = sv + ov;
         else             res = (sv < 0) ? 0 : sv;
         r[k*PSUM_BW +: PSUM_BW] = res[PSUM_BW-1:0];
      end
      return r;
   endfunction

   task automatic preload(input logic [ADDR_BW-1:0] a, input logic [ROW_BW-1:0] d);
      @(negedge clk);
      pl_addr = a; pl_data = d; pl_we = 1'b1;
      @(negedge clk);
      pl_we = 1'b0;
   endtask

   task automatic start_pass(input logic [1:0] m, input logic [ADDR_BW-1:0] base,
                             input logic [ADDR_BW-1:0] cnt);
      @(negedge clk);
      bus.start = 1'b1; bus.mode = m; bus.base_addr = base; bus.count = cnt;
      @(negedge clk);
      bus.start = 1'b0;
      bus.mode = 2'($urandom); bus.base_addr = ADDR_BW'($urandom); bus.count = ADDR_BW'($urandom);
   endtask

   task automatic check_reset_vals(input string tag);
      check({tag, "_cen"},  128'(bus.sram_cen),  128'(1));
      check({tag, "_wen"},  128'(bus.sram_wen),  128'(1));
      check({tag, "_addr"}, 128'(bus.sram_addr), 128'(0));
      check({tag, "_d"},    128'(bus.sram_d),    128'(0));
      check({tag, "_rd"},   128'(bus.ofifo_rd),  128'(0));
      check({tag, "_busy"}, 128'(bus.busy),      128'(0));
      check({tag, "_done"}, 128'(bus.done),      128'(0));
   endtask

   task automatic run_pass(input string tag, input logic [1:0] m, input logic [ADDR_BW-1:0] base,
                           input logic [ADDR_BW-1:0] cnt, input int stall_at, input int exp_lat);
      int eff, nw0, dc0, pc0, cl0, nw;
      logic [ADDR_BW-1:0] a;
      logic [ROW_BW-1:0]  o;
      logic [ADDR_BW-1:0] exp_a [$];
      logic [ROW_BW-1:0]  exp_d [$];
      eff = (m == 2'd3) ? 2 : int'(m);
      nw0 = wl_addr.size(); dc0 = done_cnt; pc0 = pop_cnt; cl0 = cen_lo_cnt;
      for (int i = 0; i < int'(cnt); i++) begin
         a = base + ADDR_BW'(i);
         o = (eff < 2) ? fifo[i] : '0;
         exp_a.push_back(a);
         exp_d.push_back(ref_row(eff, mem[a], o));
      end
      start_pass(m, base, cnt);
      if (cnt != 0) check({tag, "_busy_mid"}, 128'(bus.busy), 128'(1));
      if (stall_at >= 0) begin
         repeat (stall_at) @(negedge clk);
         hold = 1'b1;
         for (int s = 0; s < 3; s++) begin
            @(negedge clk);
            check({tag, "_stall_cen"}, 128'(bus.sram_cen), 128'(1));
            check({tag, "_stall_rd"},  128'(bus.ofifo_rd), 128'(0));
         end
         hold = 1'b0;
      end
      for (int t = 0; t < 500 && done_cnt == dc0; t++) @(negedge clk);
      @(negedge clk);
      nw = wl_addr.size() - nw0;
      check({tag, "_done_pulses"}, 128'(done_cnt - dc0), 128'(1));
      check({tag, "_latency"}, 128'(done_cyc - start_cyc), 128'(exp_lat));
      check({tag, "_busy_end"}, 128'(bus.busy), 128'(0));
      check({tag, "_writes"}, 128'(nw), 128'(cnt));
      check({tag, "_pops"}, 128'(pop_cnt - pc0), 128'((eff < 2) ? int'(cnt) : 0));
      check({tag, "_cen_cycles"}, 128'(cen_lo_cnt - cl0), 128'((eff == 0 ? 1 : 2) * int'(cnt)));
      for (int i = 0; i < int'(cnt) && i < nw; i++) begin
         check({tag, "_waddr"}, 128'(wl_addr[nw0+i]), 128'(exp_a[i]));
         check({tag, "_wdata"}, 128'(wl_data[nw0+i]), 128'(exp_d[i]));
         if (stall_at < 0)
            check({tag, "_wcycle"}, 128'(wl_cyc[nw0+i] - start_cyc),
                  128'((eff == 0) ? i + 1 : 2 * i + 2));
      end
      $display("[TB] pass %s mode=%0d base=%0d count=%0d latency=%0d writes=%0d",
               tag, m, base, cnt, done_cyc - start_cyc, nw);
   endtask

   initial begin
      logic [ROW_BW-1:0]  row, old2, old3, exp0, exp1;
      logic [ADDR_BW-1:0] b;
      int                 m, n, dc0, nw0;

      bus.start = 1'b0; bus.mode = '0; bus.base_addr = '0; bus.count = '0;
      reset = 1'b1;
      @(negedge clk);
      check_reset_vals("reset");
      repeat (2) @(negedge clk);
      reset = 1'b0;
      @(negedge clk);
      check_reset_vals("post_reset");

      // Passthrough: three pre-filled rows at 5..7, one row per cycle.
      for (int i = 0; i < 3; i++) fifo.push_back(rand_row());
      run_pass("m0_basic", 2'd0, 11'd5, 11'd3, -1, 4);

      // Accumulate with a lane overflowing and a negative lane.
      for (int i = 0; i < 2; i++) begin
         row = rand_row(); row[15:0] = 16'h7FFF; row[31:16] = 16'hFFFD;
         preload(11'd20 + ADDR_BW'(i), row);
         row = rand_row(); row[15:0] = 16'h0001; row[31:16] = 16'h0005;
         fifo.push_back(row);
      end
      run_pass("m1_acc", 2'd1, 11'd20, 11'd2, -1, 5);
      row = mem[20];
      check("m1_lane0_wrap", 128'(row[15:0]), 128'(16'h8000));
      check("m1_lane1_sum",  128'(row[31:16]), 128'(16'h0002));

      // ReLU with empty OFIFO: must not stall or pop.
      for (int i = 0; i < 2; i++) begin
         row = rand_row(); row[15:0] = 16'hFFFE; row[31:16] = 16'h0004;
         preload(11'd40 + ADDR_BW'(i), row);
      end
      run_pass("m2_relu", 2'd2, 11'd40, 11'd2, -1, 5);
      row = mem[40];
      check("m2_lanes01", 128'(row[31:0]), 128'(32'h0004_0000));

      for (int i = 0; i < 3; i++) preload(11'd60 + ADDR_BW'(i), rand_row());
      run_pass("m3_as_relu", 2'd3, 11'd60, 11'd3, -1, 7);

      // Accumulate with the OFIFO empty for three cycles while the FSM waits in RD.
      for (int i = 0; i < 3; i++) begin
         preload(11'd80 + ADDR_BW'(i), rand_row());
         fifo.push_back(rand_row());
      end
      run_pass("m1_stall", 2'd1, 11'd80, 11'd3, 1, 10);

      for (int i = 0; i < 4; i++) fifo.push_back(rand_row());
      run_pass("m0_wrap", 2'd0, 11'd2046, 11'd4, -1, 5);

      run_pass("count0", 2'd1, 11'd500, 11'd0, -1, 1);

      for (int p = 0; p < 4; p++) begin
         m = int'($urandom_range(0, 3));
         n = int'($urandom_range(1, 6));
         b = ADDR_BW'($urandom);
         for (int i = 0; i < n; i++) begin
            if (m != 0) preload(b + ADDR_BW'(i), rand_row());
            if (m < 2) fifo.push_back(rand_row());
         end
         run_pass("random", 2'(m), b, ADDR_BW'(n), -1, (m == 0) ? n + 1 : 2 * n + 1);
      end

      // Abort an accumulate pass during the write cycle of row 2.
      for (int i = 0; i < 4; i++) begin
         preload(11'd300 + ADDR_BW'(i), rand_row());
         fifo.push_back(rand_row());
      end
      exp0 = ref_row(1, mem[300], fifo[0]);
      exp1 = ref_row(1, mem[301], fifo[1]);
      old2 = mem[302];
      old3 = mem[303];
      dc0 = done_cnt; nw0 = wl_addr.size();
      start_pass(2'd1, 11'd300, 11'd4);
      repeat (5) @(negedge clk);
      reset = 1'b1;
      #1;
      check_reset_vals("abort_async");
      repeat (2) @(negedge clk);
      fifo.delete();
      reset = 1'b0;
      repeat (4) @(negedge clk);
      check("abort_no_done", 128'(done_cnt - dc0), 128'(0));
      check("abort_writes", 128'(wl_addr.size() - nw0), 128'(2));
      check("abort_row0", mem[300], exp0);
      check("abort_row1", mem[301], exp1);
      check("abort_row2", mem[302], old2);
      check("abort_row3", mem[303], old3);
      check("abort_idle_cen", 128'(bus.sram_cen), 128'(1));
      $display("[TB] pass abort mode=1 base=300 count=4 writes=%0d", wl_addr.size() - nw0);

      for (int i = 0; i < 2; i++) fifo.push_back(rand_row());
      run_pass("after_abort", 2'd0, 11'd310, 11'd2, -1, 3);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
